if_fetch_unit: RTL

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter, issues one-at-a-time requests to instruction memory over a ready handshake, and applies hazard-unit stalls and branch/jump redirects. Drives the IF/ID pipeline register with the next instruction, its PC+4, a load-enable and a flush (bubble) strobe.

---
 rtl/if_fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch stage of a five-stage MIPS pipeline. It holds the program
// counter and keeps at most one request open to instruction memory. It applies
// hazard stalls and branch/jump redirects, and drives the IF/ID register.
//
// State table:
//   state   | meaning
//   IDLE    | one cycle after reset, no request issued
//   FETCH   | request at pc is open; delivers data when imem_ready is high
//   HOLD    | fetched word is parked in instr_buf while the pipeline stalls
//   DISCARD | the old request is still open after a redirect; its data is dropped
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   stall_in                      hazard stall; holds pc and IF/ID, masks redirects
//   branch_taken_in/_target_in    branch redirect (wins over jump)
//   jump_in/jump_target_in        jump redirect
//   imem_req/imem_addr            memory request and address
//   imem_ready/imem_rdata         memory completion and instruction word
//   pc_out                        current pc register
//   PC_4_out/instr_out            IF/ID data (0 when not loading a real instruction)
//   ifid_write/ifid_flush         IF/ID load enable and bubble strobe
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  input  logic        jump_in,
  input  logic [31:0] jump_target_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] PC_4_out,
  output logic [31:0] instr_out,
  output logic        ifid_write,
  output logic        ifid_flush
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr;
  logic [31:0] instr_buf, instr_buf_nxt;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign redirect = (branch_taken_in | jump_in) & ~stall_in;
  assign target   = (branch_taken_in ? branch_target_in : jump_target_in) & ~32'h3;
  assign pc_plus4 = pc + 32'd4;
  assign pc_out   = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= '0;
      instr_buf <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      instr_buf <= instr_buf_nxt;
      // In FETCH the pc is the open request's address, so DISCARD can
      // keep presenting it after the pc has moved to the redirect target.
      if (state == FETCH) req_addr <= pc;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    instr_buf_nxt = instr_buf;
    imem_req      = 1'b0;
    imem_addr     = '0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    instr_out     = '0;
    PC_4_out      = '0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (imem_ready) begin
          if (redirect) begin
            pc_nxt     = target;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
          end else if (stall_in) begin
            instr_buf_nxt = imem_rdata;
            state_nxt     = HOLD;
          end else begin
            instr_out  = imem_rdata;
            PC_4_out   = pc_plus4;
            ifid_write = 1'b1;
            pc_nxt     = pc_plus4;
          end
        end else if (redirect) begin
          pc_nxt     = target;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          state_nxt  = DISCARD;
        end else if (!stall_in) begin
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt     = target;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          state_nxt  = FETCH;
        end else if (!stall_in) begin
          instr_out  = instr_buf;
          PC_4_out   = pc_plus4;
          ifid_write = 1'b1;
          pc_nxt     = pc_plus4;
          state_nxt  = FETCH;
        end
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = req_addr;
        if (!stall_in) begin
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
        end
        if (redirect) pc_nxt = target;
        if (imem_ready) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
